regfile_wb: RTL
===============

Name: regfile_wb

Overview:
- 32 x 32-bit general-purpose register file; the consuming end of the writeback interface.
- Accepts the writeback stage's destination, write-enable and data triple and commits it on the clock edge.
- Serves two combinational read ports to the decode stage.
- Exposes a registered record of the last committed write for debug and hazard checking.

Parameters:
- WIDTH, 32, data width of each register and of the write/read data.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_rf_wr_rdst  input  ADDR_W  write destination index (from WB o_wb_rdst).
- i_rf_wr_en  input  1  write enable (from WB o_wb_reg_write_rf).
- i_rf_wr_data  input  WIDTH  write data (from WB o_wb_mux).
- i_rf_rs1  input  ADDR_W  read port A index.
- i_rf_rs2  input  ADDR_W  read port B index.
- o_rf_rd1  output  WIDTH  read port A data, combinational.
- o_rf_rd2  output  WIDTH  read port B data, combinational.
- o_rf_last_rdst  output  ADDR_W  index of last committed write, registered.
- o_rf_last_data  output  WIDTH  data of last committed write, registered.
- o_rf_last_valid  output  1  pulses high the cycle after a committed write.
- o_rf_wr_count  output  16  count of committed writes since reset, registered, wraps.

Behaviour:
- Reset (rst high at rising edge):
  - All 32 registers cleared to 0 in that single cycle.
  - o_rf_last_rdst = 0, o_rf_last_data = 0, o_rf_last_valid = 0, o_rf_wr_count = 0.
  - Reset has priority over a simultaneous write; the write is dropped.
- Commit condition:
  - A write commits at the rising edge when rst = 0, i_rf_wr_en = 1 and i_rf_wr_rdst != 0.
  - regs[i_rf_wr_rdst] <= i_rf_wr_data.
- Register 0:
  - Hardwired zero; writes to index 0 are discarded and do not count as committed.
  - Reads of index 0 always return 0, including under bypass.
- Reads:
  - Purely combinational: o_rf_rdN = regs[i_rf_rsN], zero latency from index change.
  - Both ports are independent; rs1 == rs2 is legal and returns identical data.
- Write latency: data is visible through the array on the first cycle after the commit edge.
- Last-write record:
  - On a committed write, o_rf_last_rdst/o_rf_last_data capture the index and data, o_rf_last_valid <= 1, o_rf_wr_count <= o_rf_wr_count + 1.
  - o_rf_wr_count wraps 16'hFFFF -> 0.
  - With no committed write, o_rf_last_valid <= 0; last_rdst/last_data hold their values.
- Reset mid-stream: any write presented in the reset cycle is lost. The first post-reset write commits normally on the next edge.
- Unknown inputs: X on i_rf_wr_en is not permitted; the verification bench asserts i_rf_wr_en is known whenever rst = 0.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined: write-first bypass. When i_rf_wr_en = 1, i_rf_wr_rdst != 0 and i_rf_wr_rdst == i_rf_rsN, o_rf_rdN returns i_rf_wr_data in the same cycle, before the commit edge. This removes the WB-to-ID hazard.
- Not defined: reads always return the array contents. A same-cycle read of the register being written returns the old value; the new value appears from the next cycle.
- The bypass is suppressed while rst = 1.

Test Plan:
- Reset, then read all 32 indices on both ports -> every read returns 0; o_rf_wr_count = 0; o_rf_last_valid = 0.
- Write r5 = 32'hDEADBEEF with wr_en = 1, then read rs1 = 5, rs2 = 5 next cycle -> both return 32'hDEADBEEF; o_rf_last_rdst = 5, o_rf_last_valid = 1 for exactly one cycle; o_rf_wr_count = 1.
- Write r0 = 32'hFFFFFFFF with wr_en = 1 -> rd of r0 returns 0; o_rf_wr_count unchanged; o_rf_last_valid stays 0.
- Same-cycle write r7 = 32'h12345678 (old value 32'h0) while rs1 = 7:
  - With RF_WR_BYPASS_EN: o_rf_rd1 = 32'h12345678 in that cycle.
  - Without it: o_rf_rd1 = 0 in that cycle and 32'h12345678 the next cycle.
- Assert rst in the same cycle as a write r3 = 32'hA5A5A5A5 -> r3 reads 0 afterwards; o_rf_wr_count = 0.
- Perform 65537 writes to r1 with incrementing data -> o_rf_wr_count = 1 after wrap; r1 holds the last data written.

Source files
------------

// File: rtl/regfile_wb_if.sv
// Writeback/decode-side bundle of the register file: write triple, two read
// ports and the registered last-write debug record.
interface regfile_wb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  // Write handshake: i_rf_wr_en is the valid. The file is always ready, so a
  // write with a non-zero destination commits on the edge where it is valid.
  logic [ADDR_W-1:0] i_rf_wr_rdst;
  logic              i_rf_wr_en;
  logic [WIDTH-1:0]  i_rf_wr_data;
  logic [ADDR_W-1:0] i_rf_rs1;
  logic [ADDR_W-1:0] i_rf_rs2;
  logic [WIDTH-1:0]  o_rf_rd1;
  logic [WIDTH-1:0]  o_rf_rd2;
  logic [ADDR_W-1:0] o_rf_last_rdst;
  logic [WIDTH-1:0]  o_rf_last_data;
  logic              o_rf_last_valid;
  logic [15:0]       o_rf_wr_count;

  modport master (
    output i_rf_wr_rdst, i_rf_wr_en, i_rf_wr_data, i_rf_rs1, i_rf_rs2,
    input  o_rf_rd1, o_rf_rd2, o_rf_last_rdst, o_rf_last_data,
           o_rf_last_valid, o_rf_wr_count
  );

  modport slave (
    input  i_rf_wr_rdst, i_rf_wr_en, i_rf_wr_data, i_rf_rs1, i_rf_rs2,
    output o_rf_rd1, o_rf_rd2, o_rf_last_rdst, o_rf_last_data,
           o_rf_last_valid, o_rf_wr_count
  );
endinterface

// File: rtl/regfile_wb.sv
// 2**ADDR_W x WIDTH register file with hardwired r0, two combinational read
// ports and a last-write record. Optional write-first bypass: RF_WR_BYPASS_EN.
module regfile_wb #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  regfile_wb_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_hit;
  logic             commit;

  // Writes to r0 never reach the array, so regs[0] stays at its reset zero.
  assign wr_hit = rf.i_rf_wr_en && (rf.i_rf_wr_rdst != '0);
  assign commit = !rst && wr_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      rf.o_rf_last_rdst  <= '0;
      rf.o_rf_last_data  <= '0;
      rf.o_rf_last_valid <= 1'b0;
      rf.o_rf_wr_count   <= 16'd0;
    end else begin
      if (commit) begin
        regs[rf.i_rf_wr_rdst] <= rf.i_rf_wr_data;
        rf.o_rf_last_rdst     <= rf.i_rf_wr_rdst;
        rf.o_rf_last_data     <= rf.i_rf_wr_data;
        rf.o_rf_wr_count      <= rf.o_rf_wr_count + 16'd1;
      end
      rf.o_rf_last_valid <= commit;
    end
  end

  always_comb begin
    rf.o_rf_rd1 = (rf.i_rf_rs1 == '0) ? '0 : regs[rf.i_rf_rs1];
    rf.o_rf_rd2 = (rf.i_rf_rs2 == '0) ? '0 : regs[rf.i_rf_rs2];
`ifdef RF_WR_BYPASS_EN
    // wr_hit excludes r0, so a bypassed read of index 0 still returns zero.
    if (!rst && wr_hit && (rf.i_rf_wr_rdst == rf.i_rf_rs1)) rf.o_rf_rd1 = rf.i_rf_wr_data;
    if (!rst && wr_hit && (rf.i_rf_wr_rdst == rf.i_rf_rs2)) rf.o_rf_rd2 = rf.i_rf_wr_data;
`endif
  end
endmodule
